// File: rtl/lut_cell_using_mux.sv
// K-input LUT cell: serially loaded 2^K-bit truth table read through a 2:1 mux tree.
// The table loads MSB first; any cfg bit accepted outside LOAD restarts the load at bit 0.
//
// state  | meaning
// UNCFG  | out of reset, table cleared, waiting for the first config bit
// LOAD   | shifting config bits into the table
// ACTIVE | table complete, evaluating in_valid vectors
module lut_cell_using_mux #(
    parameter int K       = 2,
    parameter bit REG_OUT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_ready,
    output logic         cfg_done,
    input  logic         in_valid,
    input  logic [K-1:0] in,
    output logic         out_valid,
    output logic         out
);
    localparam int N  = 1 << K;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {UNCFG, LOAD, ACTIVE} state_t;

    state_t         state, state_next;
    logic [N-1:0]   tt, tt_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           ready_q;
    logic           accept;
    logic           eval;
    logic [N-1:0]   lvl;

    // Config is not taken until one clock edge has seen rst_n high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign cfg_ready = ready_q;
    assign accept    = cfg_valid & ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNCFG;
            tt    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            tt    <= tt_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        tt_next    = tt;
        cnt_next   = cnt;
        cfg_done   = 1'b0;
        if (accept) begin
            tt_next = {tt[N-2:0], cfg_bit};
            if (state == LOAD) begin
                if (cnt == CW'(N - 1)) begin
                    cfg_done   = 1'b1;
                    state_next = ACTIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end else begin
                state_next = LOAD;
                cnt_next   = CW'(1);
            end
        end
    end

    // A config bit arriving in ACTIVE takes priority over evaluation.
    assign eval = (state == ACTIVE) & in_valid & ~accept;

    // In-place reduction: level j halves the vector using in[j] as the select.
    always_comb begin
        lvl = tt;
        for (int j = 0; j < K; j++) begin
            for (int i = 0; i < N / 2; i++) begin
                if (i < (N >> (j + 1))) begin
                    lvl[i] = in[j] ? lvl[2*i+1] : lvl[2*i];
                end
            end
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic out_q, out_valid_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q       <= 1'b0;
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= eval;
                    if (eval) out_q <= lvl[0];
                end
            end
            assign out       = out_q;
            assign out_valid = out_valid_q;
        end else begin : g_comb
            assign out       = lvl[0];
            assign out_valid = eval;
        end
    endgenerate
endmodule

// File: tb/tb_lut_cell_using_mux.sv
// Directed bench: K=2 registered cell and K=3 combinational cell with hand-computed results.
module tb_lut_cell_using_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;

    logic       a_cfg_valid = 0, a_cfg_bit = 0, a_cfg_ready, a_cfg_done;
    logic       a_in_valid = 0, a_out_valid, a_out;
    logic [1:0] a_in = '0;

    logic       b_cfg_valid = 0, b_cfg_bit = 0, b_cfg_ready, b_cfg_done;
    logic       b_in_valid = 0, b_out_valid, b_out;
    logic [2:0] b_in = '0;

    always #5 clk = ~clk;

    lut_cell_using_mux #(.K(2), .REG_OUT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_valid(a_cfg_valid), .cfg_bit(a_cfg_bit),
        .cfg_ready(a_cfg_ready), .cfg_done(a_cfg_done), .in_valid(a_in_valid),
        .in(a_in), .out_valid(a_out_valid), .out(a_out)
    );

    lut_cell_using_mux #(.K(3), .REG_OUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_valid(b_cfg_valid), .cfg_bit(b_cfg_bit),
        .cfg_ready(b_cfg_ready), .cfg_done(b_cfg_done), .in_valid(b_in_valid),
        .in(b_in), .out_valid(b_out_valid), .out(b_out)
    );

    // Inputs change 1 time unit after a rising edge; registered outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (a_cfg_ready !== 1'b0 || a_out_valid !== 1'b0 || a_out !== 1'b0 || a_cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b ov=%b out=%b done=%b, required 0 0 0 0",
                     a_cfg_ready, a_out_valid, a_out, a_cfg_done);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_b: ov=%b out=%b, required 0 0", b_out_valid, b_out);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (a_cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b, required 1", a_cfg_ready);
        end
    endtask

    task automatic load_a(input logic [3:0] bits, input string name);
        for (int i = 3; i >= 0; i--) begin
            a_cfg_valid = 1'b1;
            a_cfg_bit   = bits[i];
            #1;
            checks++;
            if (a_cfg_done !== (i == 0)) begin
                errors++;
                $display("FAIL %s_done_bit%0d: got %b, required %b", name, 3 - i, a_cfg_done, (i == 0));
            end
            step();
        end
        a_cfg_valid = 1'b0;
    endtask

    task automatic test_and();
        logic [1:0] vin [4];
        logic       exp [4];
        vin = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp = '{1'b0, 1'b0, 1'b0, 1'b1};
        load_a(4'b1000, "and_load");
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in       = vin[i];
            step();
            checks++;
            if (a_out_valid !== 1'b1 || a_out !== exp[i]) begin
                errors++;
                $display("FAIL and_in%0d: ov=%b out=%b, required 1 %b", i, a_out_valid, a_out, exp[i]);
            end
        end
        a_in_valid = 1'b0;
        a_in       = 2'b00;
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_out !== 1'b1) begin
            errors++;
            $display("FAIL and_idle_hold: ov=%b out=%b, required 0 1", a_out_valid, a_out);
        end
    endtask

    task automatic test_restart_priority();
        a_cfg_valid = 1'b1;
        a_cfg_bit   = 1'b1;
        a_in_valid  = 1'b1;
        a_in        = 2'b11;
        step();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_no_eval: ov=%b, required 0", a_out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            a_cfg_valid = 1'b1;
            a_cfg_bit   = 1'b0;
            #1;
            checks++;
            if (a_cfg_done !== (i == 2)) begin
                errors++;
                $display("FAIL restart_done_bit%0d: got %b, required %b", i + 1, a_cfg_done, (i == 2));
            end
            step();
        end
        a_cfg_valid = 1'b0;
        a_in_valid  = 1'b1;
        a_in        = 2'b11;
        step();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out !== 1'b1) begin
            errors++;
            $display("FAIL restart_and11: ov=%b out=%b, required 1 1", a_out_valid, a_out);
        end
    endtask

    task automatic test_xor();
        load_a(4'b0110, "xor_load");
        a_in_valid = 1'b1;
        a_in       = 2'b11;
        step();
        checks++;
        if (a_out_valid !== 1'b1 || a_out !== 1'b0) begin
            errors++;
            $display("FAIL xor_in11: ov=%b out=%b, required 1 0", a_out_valid, a_out);
        end
        a_in = 2'b01;
        step();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out !== 1'b1) begin
            errors++;
            $display("FAIL xor_in01: ov=%b out=%b, required 1 1", a_out_valid, a_out);
        end
        step();
    endtask

    task automatic test_in_valid_during_load();
        logic [3:0] bits;
        bits       = 4'b1000;
        a_in_valid = 1'b1;
        a_in       = 2'b11;
        for (int i = 3; i >= 0; i--) begin
            a_cfg_valid = 1'b1;
            a_cfg_bit   = bits[i];
            step();
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL load_ignore_in_bit%0d: ov=%b, required 0", 3 - i, a_out_valid);
            end
        end
        a_cfg_valid = 1'b0;
        step();
        checks++;
        if (a_out_valid !== 1'b1 || a_out !== 1'b1) begin
            errors++;
            $display("FAIL first_active_eval: ov=%b out=%b, required 1 1", a_out_valid, a_out);
        end
        a_in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 2; i++) begin
            a_cfg_valid = 1'b1;
            a_cfg_bit   = 1'b1;
            step();
        end
        a_cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out !== 1'b0 || a_out_valid !== 1'b0 || a_cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out=%b ov=%b ready=%b, required 0 0 0", a_out, a_out_valid, a_cfg_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        load_a(4'b1110, "or_load");
        a_in_valid = 1'b1;
        a_in       = 2'b00;
        step();
        checks++;
        if (a_out_valid !== 1'b1 || a_out !== 1'b0) begin
            errors++;
            $display("FAIL or_in00: ov=%b out=%b, required 1 0", a_out_valid, a_out);
        end
        a_in = 2'b10;
        step();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out !== 1'b1) begin
            errors++;
            $display("FAIL or_in10: ov=%b out=%b, required 1 1", a_out_valid, a_out);
        end
    endtask

    task automatic test_parity_comb();
        logic [7:0] bits;
        logic       expv;
        logic [2:0] v;
        bits       = 8'h96;
        b_in_valid = 1'b1;
        b_in       = 3'b111;
        #1;
        checks++;
        if (b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_uncfg_ignore: ov=%b, required 0", b_out_valid);
        end
        b_in_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            b_cfg_valid = 1'b1;
            b_cfg_bit   = bits[i];
            #1;
            checks++;
            if (b_cfg_done !== (i == 0)) begin
                errors++;
                $display("FAIL parity_done_bit%0d: got %b, required %b", 7 - i, b_cfg_done, (i == 0));
            end
            step();
        end
        b_cfg_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v          = 3'(i);
            expv       = ^v;
            b_in_valid = 1'b1;
            b_in       = v;
            #1;
            checks++;
            if (b_out_valid !== 1'b1 || b_out !== expv) begin
                errors++;
                $display("FAIL parity_in%0d: ov=%b out=%b, required 1 %b", i, b_out_valid, b_out, expv);
            end
            step();
        end
        b_in_valid = 1'b0;
        #1;
        checks++;
        if (b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_idle: ov=%b, required 0", b_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_restart_priority();
        test_xor();
        test_in_valid_during_load();
        test_reset_mid_load();
        test_parity_comb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
